// File: rtl/cart_pkg.sv
// ============================================================================
//  cart_pkg
//  Shared types and header offsets for the cartridge header scanner.
//  Rev 1.0
// ============================================================================
`default_nettype none

package cart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2,
        ST_DONE = 2'd3
    } cart_state_t;

    localparam int LOGO_BYTES       = 16;
    localparam int DEF_PROBE_STRIDE = 'h40000;

    localparam logic [24:0] OFS_ENTRY       = 25'h101;
    localparam logic [24:0] OFS_LOGO_FIRST  = 25'h104;
    localparam logic [24:0] OFS_LOGO_LAST   = 25'h113;
    localparam logic [24:0] OFS_CSUM_FIRST  = 25'h134;
    localparam logic [24:0] OFS_SACHEN_MARK = 25'h140;
    localparam logic [24:0] OFS_CGB         = 25'h143;
    localparam logic [24:0] OFS_SGB         = 25'h146;
    localparam logic [24:0] OFS_MBC         = 25'h147;
    localparam logic [24:0] OFS_ROM         = 25'h148;
    localparam logic [24:0] OFS_RAM         = 25'h149;
    localparam logic [24:0] OFS_LIC         = 25'h14B;
    localparam logic [24:0] OFS_CSUM_LAST   = 25'h14C;
    localparam logic [24:0] OFS_CSUM        = 25'h14D;
    localparam logic [24:0] OFS_SACHEN_HDR  = 25'h150;
    localparam logic [24:0] OFS_SACHEN_CGB  = 25'h151;

    localparam logic [7:0]  SACHEN_MARK     = 8'hC3;

    // Byte offset within a bank -> index into the 16-byte logo store.
    function automatic logic [3:0] logo_idx(input logic [24:0] ofs);
        return 4'(ofs - OFS_LOGO_FIRST);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cart_logo_cmp.sv
// ============================================================================
//  cart_logo_cmp
//  Tracks one probe window: which logo bytes arrived, whether all matched.
//  Rev 1.0
// ============================================================================
`default_nettype none

module cart_logo_cmp
    import cart_pkg::*;
#(
    parameter int NL = 2
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            clr_i,
    input  logic [NL-1:0]   vld_i,
    input  logic [NL*4-1:0] idx_i,
    input  logic [NL-1:0]   match_i,
    output logic            hit_o
);

    logic [LOGO_BYTES-1:0] seen_q, seen_d;
    logic                  bad_q, bad_d;
    logic                  hit_q, hit_d;
    logic                  last_byte;

    always_comb begin
        seen_d    = seen_q;
        bad_d     = bad_q;
        hit_d     = hit_q;
        last_byte = 1'b0;
        if (clr_i) begin
            seen_d = '0;
            bad_d  = 1'b0;
            hit_d  = 1'b0;
        end else begin
            for (int l = 0; l < NL; l++) begin
                if (vld_i[l]) begin
                    seen_d[idx_i[4*l +: 4]] = 1'b1;
                    if (!match_i[l])
                        bad_d = 1'b1;
                    if (idx_i[4*l +: 4] == 4'(LOGO_BYTES - 1))
                        last_byte = 1'b1;
                end
            end
            // A window only counts once its final byte lands with none missing.
            if (last_byte && (&seen_d) && !bad_d)
                hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            seen_q <= '0;
            bad_q  <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            seen_q <= seen_d;
            bad_q  <= bad_d;
            hit_q  <= hit_d;
        end
    end

    assign hit_o = hit_q;

endmodule

`default_nettype wire

// File: rtl/cart_hdr_scan.sv
// ============================================================================
//  cart_hdr_scan
//  Snoops a ROM download: header fields, checksum and multicart logo probes.
//  Optional Sachen handling when CART_HDR_SACHEN_EN is defined.
//  Rev 1.0
// ============================================================================
`default_nettype none

module cart_hdr_scan
    import cart_pkg::*;
#(
    parameter int DW           = 16,
    parameter int NPROBE       = 4,
    parameter int PROBE_STRIDE = DEF_PROBE_STRIDE
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cart_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [DW-1:0]     ioctl_dout,
    output logic [7:0]        mbc_type,
    output logic [7:0]        rom_size,
    output logic [7:0]        ram_size,
    output logic [7:0]        sgb_flag,
    output logic [7:0]        old_licensee,
    output logic              cgb_flag,
    output logic [NPROBE-1:0] probe_hit,
    output logic              hdr_valid,
    output logic              hdr_csum_ok,
    output logic              scan_done
`ifdef CART_HDR_SACHEN_EN
    ,
    output logic              sachen
`endif
);

    localparam int NL = DW / 8;

    cart_state_t state_q, state_d;
    logic        dl_q, armed_q;
    logic        dl_rise, dl_fall, wr_act, hdr_end;

    logic [24:0] lane_addr [NL];
    logic [7:0]  lane_byte [NL];

    logic [7:0]  logo_q [LOGO_BYTES];
    logic [7:0]  logo_d [LOGO_BYTES];
    logic [7:0]  mbc_q, mbc_d, rom_q, rom_d, ram_q, ram_d;
    logic [7:0]  sgb_q, sgb_d, lic_q, lic_d, csum_q, csum_d;
    logic        cgb_q, cgb_d, valid_q, valid_d, ok_q, ok_d;
`ifdef CART_HDR_SACHEN_EN
    logic [7:0]  b101_q, b101_d, b140_q, b140_d;
    logic        sachen_q, sachen_d, sachen_img;
`endif

    for (genvar l = 0; l < NL; l++) begin : g_lane
        assign lane_addr[l] = ioctl_addr + 25'(l);
        assign lane_byte[l] = ioctl_dout[8*l +: 8];
    end

    // armed_q keeps a download already high at reset release from looking like an edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
            dl_q    <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            dl_q    <= cart_download;
        end
    end

    assign dl_rise = armed_q &  cart_download & ~dl_q;
    assign dl_fall = armed_q & ~cart_download &  dl_q;
    assign wr_act  = ioctl_wr & cart_download & ~dl_rise;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (dl_rise)
            state_d = ST_HDR;
        else if (dl_fall && (state_q == ST_HDR || state_q == ST_BODY))
            state_d = ST_DONE;
        else if (state_q == ST_HDR && hdr_end)
            state_d = ST_BODY;
    end

`ifdef CART_HDR_SACHEN_EN
    assign sachen_img = (b101_q != SACHEN_MARK) && (b140_q == SACHEN_MARK);
`endif

    always_comb begin
        logo_d  = logo_q;
        mbc_d   = mbc_q;
        rom_d   = rom_q;
        ram_d   = ram_q;
        sgb_d   = sgb_q;
        lic_d   = lic_q;
        csum_d  = csum_q;
        cgb_d   = cgb_q;
        valid_d = valid_q;
        ok_d    = ok_q;
        hdr_end = 1'b0;
`ifdef CART_HDR_SACHEN_EN
        b101_d   = b101_q;
        b140_d   = b140_q;
        sachen_d = sachen_q;
`endif
        if (dl_rise) begin
            logo_d  = '{default: '0};
            mbc_d   = '0;
            rom_d   = '0;
            ram_d   = '0;
            sgb_d   = '0;
            lic_d   = '0;
            csum_d  = '0;
            cgb_d   = 1'b0;
            valid_d = 1'b0;
            ok_d    = 1'b0;
`ifdef CART_HDR_SACHEN_EN
            b101_d   = '0;
            b140_d   = '0;
            sachen_d = 1'b0;
`endif
        end else if (wr_act && state_q == ST_HDR) begin
            // Lanes are walked low to high so the checksum sees bytes in address order.
            for (int l = 0; l < NL; l++) begin
                if (lane_addr[l] >= OFS_LOGO_FIRST && lane_addr[l] <= OFS_LOGO_LAST)
                    logo_d[logo_idx(lane_addr[l])] = lane_byte[l];
                case (lane_addr[l])
                    OFS_CGB: cgb_d = lane_byte[l][7];
                    OFS_SGB: sgb_d = lane_byte[l];
                    OFS_MBC: mbc_d = lane_byte[l];
                    OFS_ROM: rom_d = lane_byte[l];
                    OFS_RAM: ram_d = lane_byte[l];
                    OFS_LIC: lic_d = lane_byte[l];
`ifdef CART_HDR_SACHEN_EN
                    OFS_ENTRY:       b101_d = lane_byte[l];
                    OFS_SACHEN_MARK: b140_d = lane_byte[l];
`endif
                    default: ;
                endcase
                if (lane_addr[l] >= OFS_CSUM_FIRST && lane_addr[l] <= OFS_CSUM_LAST)
                    csum_d = csum_d - lane_byte[l] - 8'd1;
                if (lane_addr[l] == OFS_CSUM) begin
                    valid_d = 1'b1;
                    ok_d    = (csum_d == lane_byte[l]);
                    hdr_end = 1'b1;
                end
            end
        end
`ifdef CART_HDR_SACHEN_EN
        else if (wr_act && state_q == ST_BODY && sachen_img) begin
            for (int l = 0; l < NL; l++) begin
                if (lane_addr[l] == OFS_SACHEN_HDR) begin
                    sachen_d = 1'b1;
                    mbc_d    = '0;
                    rom_d    = '0;
                    ram_d    = '0;
                    sgb_d    = '0;
                    lic_d    = '0;
                end
                if (lane_addr[l] == OFS_SACHEN_CGB)
                    cgb_d = lane_byte[l][7];
            end
        end
`endif
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            logo_q  <= '{default: '0};
            mbc_q   <= '0;
            rom_q   <= '0;
            ram_q   <= '0;
            sgb_q   <= '0;
            lic_q   <= '0;
            csum_q  <= '0;
            cgb_q   <= 1'b0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
`ifdef CART_HDR_SACHEN_EN
            b101_q   <= '0;
            b140_q   <= '0;
            sachen_q <= 1'b0;
`endif
        end else begin
            logo_q  <= logo_d;
            mbc_q   <= mbc_d;
            rom_q   <= rom_d;
            ram_q   <= ram_d;
            sgb_q   <= sgb_d;
            lic_q   <= lic_d;
            csum_q  <= csum_d;
            cgb_q   <= cgb_d;
            valid_q <= valid_d;
            ok_q    <= ok_d;
`ifdef CART_HDR_SACHEN_EN
            b101_q   <= b101_d;
            b140_q   <= b140_d;
            sachen_q <= sachen_d;
`endif
        end
    end

    for (genvar k = 0; k < NPROBE; k++) begin : g_probe
        localparam logic [24:0] BASE = 25'((k + 1) * PROBE_STRIDE);
        logic [NL-1:0]   vld;
        logic [NL-1:0]   match;
        logic [NL*4-1:0] idx;

        for (genvar l = 0; l < NL; l++) begin : g_plane
            logic [24:0] ofs;
            assign ofs           = lane_addr[l] - BASE;
            assign vld[l]        = wr_act && (state_q == ST_BODY) && (lane_addr[l] >= BASE)
                                   && (ofs >= OFS_LOGO_FIRST) && (ofs <= OFS_LOGO_LAST);
            assign idx[4*l +: 4] = logo_idx(ofs);
            assign match[l]      = (lane_byte[l] == logo_q[logo_idx(ofs)]);
        end

        cart_logo_cmp #(.NL(NL)) u_cmp (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .clr_i   (dl_rise),
            .vld_i   (vld),
            .idx_i   (idx),
            .match_i (match),
            .hit_o   (probe_hit[k])
        );
    end

    assign mbc_type     = mbc_q;
    assign rom_size     = rom_q;
    assign ram_size     = ram_q;
    assign sgb_flag     = sgb_q;
    assign old_licensee = lic_q;
    assign cgb_flag     = cgb_q;
    assign hdr_valid    = valid_q;
    assign hdr_csum_ok  = ok_q;
    assign scan_done    = (state_q == ST_DONE);
`ifdef CART_HDR_SACHEN_EN
    assign sachen       = sachen_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cart_hdr_scan.sv
// ============================================================================
//  tb_cart_hdr_scan
//  Drives a DW=16 and a DW=8 instance with the same image; checks both.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_cart_hdr_scan;

    localparam int NPROBE = 4;
    localparam int STRIDE = 'h40000;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        cart_download;
    logic        wr16, wr8;
    logic [24:0] addr16, addr8;
    logic [15:0] dout16;
    logic [7:0]  dout8;

    logic [7:0]  mbc_o [2];
    logic [7:0]  rom_o [2];
    logic [7:0]  ram_o [2];
    logic [7:0]  sgb_o [2];
    logic [7:0]  lic_o [2];
    logic        cgb_o [2];
    logic [3:0]  hit_o [2];
    logic        val_o [2];
    logic        ok_o  [2];
    logic        done_o[2];
`ifdef CART_HDR_SACHEN_EN
    logic        sach_o[2];
`endif

    int ncmp = 0;
    int nerr = 0;

    logic [7:0] img [int];
    logic [7:0] hdr [0:351];

    always #5 clk_sys = ~clk_sys;

    cart_hdr_scan #(.DW(16), .NPROBE(NPROBE), .PROBE_STRIDE(STRIDE)) u_dut16 (
        .clk_sys(clk_sys), .reset_n(reset_n), .cart_download(cart_download),
        .ioctl_wr(wr16), .ioctl_addr(addr16), .ioctl_dout(dout16),
        .mbc_type(mbc_o[0]), .rom_size(rom_o[0]), .ram_size(ram_o[0]),
        .sgb_flag(sgb_o[0]), .old_licensee(lic_o[0]), .cgb_flag(cgb_o[0]),
        .probe_hit(hit_o[0]), .hdr_valid(val_o[0]), .hdr_csum_ok(ok_o[0]),
        .scan_done(done_o[0])
`ifdef CART_HDR_SACHEN_EN
        , .sachen(sach_o[0])
`endif
    );

    cart_hdr_scan #(.DW(8), .NPROBE(NPROBE), .PROBE_STRIDE(STRIDE)) u_dut8 (
        .clk_sys(clk_sys), .reset_n(reset_n), .cart_download(cart_download),
        .ioctl_wr(wr8), .ioctl_addr(addr8), .ioctl_dout(dout8),
        .mbc_type(mbc_o[1]), .rom_size(rom_o[1]), .ram_size(ram_o[1]),
        .sgb_flag(sgb_o[1]), .old_licensee(lic_o[1]), .cgb_flag(cgb_o[1]),
        .probe_hit(hit_o[1]), .hdr_valid(val_o[1]), .hdr_csum_ok(ok_o[1]),
        .scan_done(done_o[1])
`ifdef CART_HDR_SACHEN_EN
        , .sachen(sach_o[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic string dtag(input string tag, input int d);
        return $sformatf("%s/dw%0d", tag, (d == 0) ? 16 : 8);
    endfunction

    function automatic logic [7:0] rd(input int a);
        if (img.exists(a))
            return img[a];
        return 8'h00;
    endfunction

    // Reference: every output derived from the set of bytes the scanner accepted.
    task automatic check_model(input string tag, input logic exp_done);
        logic       hv, ok, cgb, sach, full, eq;
        logic [7:0] x, b, mbc_e, rom_e, ram_e, sgb_e, lic_e;
        logic [3:0] hit_e;
        hv = img.exists('h14D);
        x  = 8'h00;
        for (int a = 'h134; a <= 'h14C; a++)
            x = x - rd(a) - 8'd1;
        ok    = hv && (x == rd('h14D));
        mbc_e = rd('h147);
        rom_e = rd('h148);
        ram_e = rd('h149);
        sgb_e = rd('h146);
        lic_e = rd('h14B);
        b     = rd('h143);
        cgb   = b[7];
        hit_e = '0;
        for (int k = 0; k < NPROBE; k++) begin
            full = 1'b1;
            eq   = 1'b1;
            for (int i = 0; i < 16; i++) begin
                int a;
                a = (k + 1) * STRIDE + 'h104 + i;
                if (!img.exists(a))
                    full = 1'b0;
                else if (img[a] != rd('h104 + i))
                    eq = 1'b0;
            end
            hit_e[k] = hv && full && eq;
        end
        sach = 1'b0;
`ifdef CART_HDR_SACHEN_EN
        if (hv && rd('h101) != 8'hC3 && rd('h140) == 8'hC3 && img.exists('h150)) begin
            sach  = 1'b1;
            mbc_e = '0; rom_e = '0; ram_e = '0; sgb_e = '0; lic_e = '0;
            if (img.exists('h151)) begin
                b   = rd('h151);
                cgb = b[7];
            end
        end
`endif
        for (int d = 0; d < 2; d++) begin
            chk({dtag(tag, d), "/hdr_valid"}, 32'(val_o[d]), 32'(hv));
            chk({dtag(tag, d), "/csum_ok"},   32'(ok_o[d]),  32'(ok));
            chk({dtag(tag, d), "/mbc"},       32'(mbc_o[d]), 32'(mbc_e));
            chk({dtag(tag, d), "/rom"},       32'(rom_o[d]), 32'(rom_e));
            chk({dtag(tag, d), "/ram"},       32'(ram_o[d]), 32'(ram_e));
            chk({dtag(tag, d), "/sgb"},       32'(sgb_o[d]), 32'(sgb_e));
            chk({dtag(tag, d), "/lic"},       32'(lic_o[d]), 32'(lic_e));
            chk({dtag(tag, d), "/cgb"},       32'(cgb_o[d]), 32'(cgb));
            chk({dtag(tag, d), "/probe_hit"}, 32'(hit_o[d]), 32'(hit_e));
            chk({dtag(tag, d), "/scan_done"}, 32'(done_o[d]), 32'(exp_done));
`ifdef CART_HDR_SACHEN_EN
            chk({dtag(tag, d), "/sachen"},    32'(sach_o[d]), 32'(sach));
`endif
        end
        if (sach) ;
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    // One byte per call to the DW=8 instance; the DW=16 instance gets the pair on odd bytes.
    task automatic wr_byte(input int a, input logic [7:0] b);
        img[a] = b;
        wr8    = 1'b1;
        addr8  = 25'(a);
        dout8  = b;
        if ((a & 1) == 1) begin
            wr16   = 1'b1;
            addr16 = 25'(a - 1);
            dout16 = {b, rd(a - 1)};
        end
        cyc();
        wr8  = 1'b0;
        wr16 = 1'b0;
        if ($urandom_range(0, 3) == 0)
            cyc();
    endtask

    task automatic rand_hdr();
        for (int i = 0; i < 352; i++)
            hdr[i] = 8'($urandom);
        hdr['h101] = 8'hC3;
    endtask

    task automatic set_csum(input bit good);
        logic [7:0] x;
        x = 8'h00;
        for (int a = 'h134; a <= 'h14C; a++)
            x = x - hdr[a] - 8'd1;
        hdr['h14D] = good ? x : x + 8'd1;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int a = lo; a <= hi; a++)
            wr_byte(a, hdr[a]);
    endtask

    // kind: 0 exact logo copy, 1 one byte differs, 2 one pair missing, 3 not written
    task automatic send_win(input int k, input int kind);
        int         base;
        logic [7:0] b;
        base = (k + 1) * STRIDE;
        if (kind != 3) begin
            for (int off = 'h100; off < 'h118; off++) begin
                if (!(kind == 2 && (off == 'h10A || off == 'h10B))) begin
                    b = (off >= 'h104 && off <= 'h113) ? hdr[off] : 8'($urandom);
                    if (kind == 1 && off == 'h10F)
                        b = b ^ 8'h5A;
                    wr_byte(base + off, b);
                end
            end
        end
    endtask

    task automatic start_dl();
        cart_download = 1'b1;
        cyc();
        img.delete();
    endtask

    // End the download, check results, then confirm they hold while stray strobes arrive.
    task automatic end_dl(input string tag);
        cart_download = 1'b0;
        cyc();
        cyc();
        check_model(tag, 1'b1);
        wr8    = 1'b1; addr8  = 25'h000147; dout8  = 8'($urandom);
        wr16   = 1'b1; addr16 = 25'h000146; dout16 = 16'($urandom);
        repeat (3) cyc();
        wr8 = 1'b0;
        wr16 = 1'b0;
        cyc();
        check_model({tag, "/hold"}, 1'b1);
    endtask

    initial begin
        reset_n       = 1'b0;
        cart_download = 1'b0;
        wr16 = 1'b0; wr8 = 1'b0;
        addr16 = '0; addr8 = '0; dout16 = '0; dout8 = '0;
        repeat (3) cyc();
        check_model("reset", 1'b0);

        // Download already high when reset releases: no scan must start.
        cart_download = 1'b1;
        cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
        wr8 = 1'b1; addr8 = 25'h147; dout8 = 8'h33;
        wr16 = 1'b1; addr16 = 25'h146; dout16 = 16'h3344;
        cyc();
        wr8 = 1'b0; wr16 = 1'b0;
        cyc();
        check_model("no_edge", 1'b0);
        cart_download = 1'b0;
        repeat (2) cyc();
        check_model("no_edge_fall", 1'b0);

        // Tetris-style header, good checksum 0x0A.
        rand_hdr();
        for (int a = 'h134; a <= 'h14C; a++) hdr[a] = 8'h00;
        hdr['h134] = "T"; hdr['h135] = "E"; hdr['h136] = "T";
        hdr['h137] = "R"; hdr['h138] = "I"; hdr['h139] = "S";
        hdr['h14B] = 8'h01; hdr['h14C] = 8'h01; hdr['h14D] = 8'h0A;
        start_dl();
        send_range(0, 'h14C);
        for (int d = 0; d < 2; d++) chk(dtag("tetris/pre_valid", d), 32'(val_o[d]), 32'd0);
        send_range('h14D, 'h14D);
        for (int d = 0; d < 2; d++) chk(dtag("tetris/valid_lat", d), 32'(val_o[d]), 32'd1);
        send_range('h14E, 'h15F);
        end_dl("tetris");
        for (int d = 0; d < 2; d++) begin
            chk(dtag("tetris/ok_spec", d), 32'(ok_o[d]), 32'd1);
            chk(dtag("tetris/mbc_spec", d), 32'(mbc_o[d]), 32'd0);
        end

        // Same header, wrong checksum byte.
        hdr['h14D] = 8'h0B;
        start_dl();
        send_range(0, 'h15F);
        end_dl("tetris_bad");
        for (int d = 0; d < 2; d++) begin
            chk(dtag("tetris_bad/ok_spec", d), 32'(ok_o[d]), 32'd0);
            chk(dtag("tetris_bad/valid_spec", d), 32'(val_o[d]), 32'd1);
        end

        // 1 MiB multicart: copies at 0x40000 and 0xC0000 only, plus a write past the last probe.
        rand_hdr();
        set_csum(1'b1);
        start_dl();
        send_range(0, 'h15F);
        send_win(0, 0);
        send_win(1, 1);
        send_win(2, 0);
        send_win(3, 3);
        send_win(NPROBE, 0);
        end_dl("multicart");
        for (int d = 0; d < 2; d++) chk(dtag("multicart/hit_spec", d), 32'(hit_o[d]), 32'b0101);

        // Download drops inside the header.
        rand_hdr();
        set_csum(1'b1);
        start_dl();
        send_range(0, 'h121);
        end_dl("early_drop");
        for (int d = 0; d < 2; d++) begin
            chk(dtag("early_drop/valid_spec", d), 32'(val_o[d]), 32'd0);
            chk(dtag("early_drop/done_spec", d), 32'(done_o[d]), 32'd1);
        end

        // Restart mid-body: everything clears on the new edge, rescan is correct.
        rand_hdr();
        set_csum(1'b1);
        hdr['h147] = 8'h13;
        start_dl();
        send_range(0, 'h15F);
        send_win(0, 0);
        cart_download = 1'b0;
        cyc();
        cart_download = 1'b1;
        cyc();
        img.delete();
        check_model("restart_clear", 1'b0);
        rand_hdr();
        set_csum(1'b1);
        send_range(0, 'h15F);
        send_win(0, 1);
        send_win(1, 0);
        send_win(2, 2);
        send_win(3, 0);
        end_dl("restart_rescan");

        // Sachen-style image.
        rand_hdr();
        hdr['h101] = 8'h00; hdr['h140] = 8'hC3; hdr['h151] = 8'h80;
        hdr['h143] = 8'h00; hdr['h147] = 8'h1B;
        set_csum(1'b1);
        start_dl();
        send_range(0, 'h15F);
        send_win(0, 0);
        end_dl("sachen");
`ifdef CART_HDR_SACHEN_EN
        for (int d = 0; d < 2; d++) begin
            chk(dtag("sachen/flag_spec", d), 32'(sach_o[d]), 32'd1);
            chk(dtag("sachen/cgb_spec", d), 32'(cgb_o[d]), 32'd1);
            chk(dtag("sachen/mbc_spec", d), 32'(mbc_o[d]), 32'd0);
        end
`endif

        // Randomised images.
        for (int it = 0; it < 5; it++) begin
            rand_hdr();
            set_csum($urandom_range(0, 1) == 1);
            start_dl();
            if ($urandom_range(0, 4) == 0) begin
                send_range(0, 2 * $urandom_range('h90, 'hA5) + 1);
            end else begin
                send_range(0, 'h15F);
                for (int k = 0; k < NPROBE; k++)
                    send_win(k, $urandom_range(0, 3));
            end
            end_dl($sformatf("random%0d", it));
        end

        // Reset with results present forces everything back to zero.
        reset_n = 1'b0;
        cyc();
        img.delete();
        check_model("reset_again", 1'b0);
        reset_n = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

`default_nettype wire
